if_fetch: RTL and testbench

- Instruction-fetch stage of the in-order RV64 pipeline.
- Owns the PC and issues 64-bit-aligned requests to the instruction SRAM.
- Presents pc/pc_valid to the decode stage; decode latches them and consumes inst_sram_rdata the following cycle.
- Applies branch redirects from execute, and holds a pending redirect across pipeline stalls.

---
 rtl/if_fetch_if.sv | 9 +
 rtl/if_fetch.sv | 109 ++++++++++
 tb/tb_if_fetch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Instruction-SRAM request channel between the fetch stage and the SRAM.
interface if_fetch_if;
    logic        inst_sram_req;
    logic [63:0] inst_sram_addr;
    logic        inst_sram_gnt;

    modport master (output inst_sram_req, output inst_sram_addr, input  inst_sram_gnt);
    modport slave  (input  inst_sram_req, input  inst_sram_addr, output inst_sram_gnt);
endinterface

// File: rtl/if_fetch.sv
// RV64 instruction-fetch stage: owns the PC, issues line-aligned SRAM requests,
// applies EX redirects and holds a redirect that arrives while IF is stalled.
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned BR_WD    = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       stall,
    input  logic [BR_WD-1:0] br_bus,
    if_fetch_if.master       sram,
    output logic             pc_valid,
    output logic [63:0]      pc,
    output logic             fetch_misalign,
    output logic             stallreq_if
);
    localparam int unsigned PC_W = 64;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc_n;
    logic            pc_valid_n;
    logic            redir_pend, redir_pend_n;
    logic [PC_W-1:0] redir_addr, redir_addr_n;

    logic            br_e;
    logic [PC_W-1:0] br_addr;
    logic            if_stall;
    logic            req;
    logic            unused_stall;

    assign br_e         = br_bus[BR_WD-1];
    assign br_addr      = br_bus[PC_W-1:0];
    assign if_stall     = stall[0];
    assign unused_stall = ^stall[5:1];

    // Outputs are pure functions of the registered state (plus gnt for the stall request).
    assign fetch_misalign      = pc_valid & (pc[1:0] != 2'b00);
    assign req                 = pc_valid & (state == RUN) & ~fetch_misalign;
    assign sram.inst_sram_req  = req;
    assign sram.inst_sram_addr = {pc[PC_W-1:3], 3'b000};
    assign stallreq_if         = req & ~sram.inst_sram_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pc_valid   <= 1'b0;
            redir_pend <= 1'b0;
            redir_addr <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pc_valid   <= pc_valid_n;
            redir_pend <= redir_pend_n;
            redir_addr <= redir_addr_n;
        end
    end

    // Next-state / next-PC selection; a fresh br_e always outranks a pending one.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pc_valid_n   = pc_valid;
        redir_pend_n = redir_pend;
        redir_addr_n = redir_addr;

        unique case (state)
            BOOT: begin
                state_n    = RUN;
                pc_valid_n = 1'b1;
            end
            RUN, HALT: begin
                if (br_e) begin
                    state_n = RUN;
                    if (!if_stall) begin
                        pc_n         = br_addr;
                        pc_valid_n   = 1'b1;
                        redir_pend_n = 1'b0;
                    end else begin
                        redir_pend_n = 1'b1;
                        redir_addr_n = br_addr;
                    end
                end else if (state == RUN) begin
                    if (fetch_misalign) begin
                        state_n    = HALT;
                        pc_valid_n = 1'b0;
                    end else if (redir_pend && !if_stall) begin
                        // Old fetch is dead, so the grant is irrelevant here.
                        pc_n         = redir_addr;
                        pc_valid_n   = 1'b1;
                        redir_pend_n = 1'b0;
                    end else if (!if_stall && req && sram.inst_sram_gnt) begin
                        pc_n = pc + PC_W'(4);
                    end
                end
            end
            default: begin
                state_n    = BOOT;
                pc_valid_n = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed scoreboard bench for if_fetch: stimulus queues hand-computed outputs
// per cycle, a negedge monitor pops and compares them.
module tb_if_fetch;
    localparam logic [63:0] P = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic [64:0] br_bus;
    logic        pc_valid;
    logic [63:0] pc;
    logic        fetch_misalign;
    logic        stallreq_if;

    if_fetch_if sram ();

    if_fetch #(.RESET_PC(P), .BR_WD(65)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .br_bus         (br_bus),
        .sram           (sram.master),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .fetch_misalign (fetch_misalign),
        .stallreq_if    (stallreq_if)
    );

    typedef struct {
        string       name;
        logic        req;
        logic [63:0] addr;
        logic [63:0] pc;
        logic        pv;
        logic        mis;
        logic        sreq;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (sram.inst_sram_req !== e.req || sram.inst_sram_addr !== e.addr ||
                pc !== e.pc || pc_valid !== e.pv || fetch_misalign !== e.mis ||
                stallreq_if !== e.sreq) begin
                miscompares++;
                $display("FAIL %s: got req=%b addr=%h pc=%h pv=%b mis=%b sreq=%b, want req=%b addr=%h pc=%h pv=%b mis=%b sreq=%b",
                         e.name, sram.inst_sram_req, sram.inst_sram_addr, pc, pc_valid,
                         fetch_misalign, stallreq_if, e.req, e.addr, e.pc, e.pv, e.mis, e.sreq);
            end
        end
    end

    task automatic expect_out(input string name, input logic r, input logic [63:0] a,
                              input logic [63:0] p, input logic v, input logic m, input logic s);
        exp_t e;
        e.name = name; e.req = r; e.addr = a; e.pc = p; e.pv = v; e.mis = m; e.sreq = s;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic e, input logic [63:0] a);
        br_bus = {e, a};
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 6'd0;
        br_bus = '0;
        sram.inst_sram_gnt = 1'b1;
        cyc();

        // Reset and boot
        expect_out("reset", 0, P, P, 0, 0, 0); cyc();
        rst_n = 1'b1;
        expect_out("boot", 0, P, P, 0, 0, 0); cyc();
        expect_out("run_pc0", 1, P, P, 1, 0, 0); cyc();

        // Grant withheld for three cycles at pc+4
        sram.inst_sram_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("gnt_wait", 1, P, P + 64'h4, 1, 0, 1); cyc();
        end
        sram.inst_sram_gnt = 1'b1;
        expect_out("gnt_back", 1, P, P + 64'h4, 1, 0, 0); cyc();
        expect_out("run_pc8", 1, P + 64'h8, P + 64'h8, 1, 0, 0);

        // Unstalled redirect
        br(1, P + 64'h100); cyc();
        br(0, '0);
        expect_out("br_target", 1, P + 64'h100, P + 64'h100, 1, 0, 0); cyc();

        // Redirect during a four-cycle stall
        stall = 6'd1;
        br(1, P + 64'h200);
        expect_out("stall_br", 1, P + 64'h100, P + 64'h104, 1, 0, 0); cyc();
        br(0, '0);
        for (int i = 0; i < 3; i++) begin
            expect_out("stall_hold", 1, P + 64'h100, P + 64'h104, 1, 0, 0); cyc();
        end
        stall = 6'd0;
        expect_out("stall_rel", 1, P + 64'h100, P + 64'h104, 1, 0, 0); cyc();
        expect_out("pend_target", 1, P + 64'h200, P + 64'h200, 1, 0, 0); cyc();

        // Two redirects inside one stall window: newest wins
        stall = 6'd1;
        br(1, P + 64'h300);
        expect_out("two_br_a", 1, P + 64'h200, P + 64'h204, 1, 0, 0); cyc();
        br(0, '0);
        expect_out("two_br_b", 1, P + 64'h200, P + 64'h204, 1, 0, 0); cyc();
        br(1, P + 64'h400);
        expect_out("two_br_c", 1, P + 64'h200, P + 64'h204, 1, 0, 0); cyc();
        br(0, '0);
        expect_out("two_br_d", 1, P + 64'h200, P + 64'h204, 1, 0, 0); cyc();
        stall = 6'd0;
        expect_out("two_br_rel", 1, P + 64'h200, P + 64'h204, 1, 0, 0); cyc();
        expect_out("newest_wins", 1, P + 64'h400, P + 64'h400, 1, 0, 0); cyc();

        // Misaligned target: one misalign cycle, then HALT until a new redirect
        br(1, P + 64'h102);
        expect_out("pre_mis", 1, P + 64'h400, P + 64'h404, 1, 0, 0); cyc();
        br(0, '0);
        expect_out("misalign", 0, P + 64'h100, P + 64'h102, 1, 1, 0); cyc();
        expect_out("halt_a", 0, P + 64'h100, P + 64'h102, 0, 0, 0); cyc();
        expect_out("halt_b", 0, P + 64'h100, P + 64'h102, 0, 0, 0); cyc();
        br(1, P);
        expect_out("halt_br", 0, P + 64'h100, P + 64'h102, 0, 0, 0); cyc();
        br(0, '0);
        expect_out("resume", 1, P, P, 1, 0, 0); cyc();

        // Async reset during a stall with a redirect pending
        stall = 6'd1;
        sram.inst_sram_gnt = 1'b0;
        br(1, P + 64'h500);
        expect_out("pre_rst", 1, P, P + 64'h4, 1, 0, 1); cyc();
        br(0, '0);
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, P, P, 0, 0, 0); cyc();
        stall = 6'd0;
        sram.inst_sram_gnt = 1'b1;
        rst_n = 1'b1;
        expect_out("reboot", 0, P, P, 0, 0, 0); cyc();
        expect_out("rerun_pc0", 1, P, P, 1, 0, 0); cyc();
        expect_out("no_stale_redir", 1, P, P + 64'h4, 1, 0, 0); cyc();

        cyc();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
